// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the mm:ss stopwatch: clock-enable dividers, input
// synchronisers, pause debounce, RUN/PAUSE/ADJ mode FSM and counter strobes.
module stopwatch_ctrl #(
   parameter int unsigned RUN_DIV   = 100_000_000,
   parameter int unsigned ADJ_DIV   = 50_000_000,
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter int unsigned SCAN_DIV  = 100_000,
   parameter int unsigned DEB_DIV   = 131_072,
   parameter int unsigned CNT_W     = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_pause,
   input  logic btn_clr,
   input  logic adj,
   input  logic sel,
   input  logic sec_wrap,
   output logic sec_inc,
   output logic min_inc,
   output logic clr,
   output logic blink_en,
   output logic blink_phase,
   output logic scan_en,
   output logic running
);

   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_DIV - 1);
   localparam logic [CNT_W-1:0] ADJ_LAST   = CNT_W'(ADJ_DIV - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_PAUSE   = 2'd0,
      ST_RUN     = 2'd1,
      ST_ADJ_MIN = 2'd2,
      ST_ADJ_SEC = 2'd3
   } state_t;

   state_t state, state_nxt;
   logic   run_flag, run_flag_nxt;

   logic [1:0] pause_sync, clr_sync, adj_sync, sel_sync;
   logic       pause_s, clr_s, adj_s, sel_s;

   logic [CNT_W-1:0] run_cnt, adj_cnt, blink_cnt, scan_cnt, deb_cnt;
   logic             run_tick, adj_tick, blink_tick, scan_tick, deb_tick;

   logic [2:0] deb_shift;
   logic [2:0] deb_shift_nxt;
   logic       pause_pulse;

   logic sec_inc_nxt, min_inc_nxt;
   logic adj_entry;
   logic in_adj;

   // Two-flop synchronisers for all asynchronous switches and buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_sync <= '0;
         clr_sync   <= '0;
         adj_sync   <= '0;
         sel_sync   <= '0;
      end else begin
         pause_sync <= {pause_sync[0], btn_pause};
         clr_sync   <= {clr_sync[0], btn_clr};
         adj_sync   <= {adj_sync[0], adj};
         sel_sync   <= {sel_sync[0], sel};
      end
   end

   assign pause_s = pause_sync[1];
   assign clr_s   = clr_sync[1];
   assign adj_s   = adj_sync[1];
   assign sel_s   = sel_sync[1];
   assign clr     = clr_s;

   assign run_tick   = (run_cnt == RUN_LAST);
   assign adj_tick   = (adj_cnt == ADJ_LAST);
   assign blink_tick = (blink_cnt == BLINK_LAST);
   assign scan_tick  = (scan_cnt == SCAN_LAST);
   assign deb_tick   = (deb_cnt == DEB_LAST);

   // Free-running dividers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         scan_cnt  <= '0;
         deb_cnt   <= '0;
      end else begin
         blink_cnt <= blink_tick ? '0 : blink_cnt + CNT_ONE;
         scan_cnt  <= scan_tick  ? '0 : scan_cnt + CNT_ONE;
         deb_cnt   <= deb_tick   ? '0 : deb_cnt + CNT_ONE;
      end
   end

   // Run divider freezes outside RUN so a resume keeps the fractional second
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
         adj_cnt <= '0;
      end else begin
         if (clr_s)
            run_cnt <= '0;
         else if (state == ST_RUN)
            run_cnt <= run_tick ? '0 : run_cnt + CNT_ONE;

         if (clr_s || adj_entry)
            adj_cnt <= '0;
         else if (in_adj)
            adj_cnt <= adj_tick ? '0 : adj_cnt + CNT_ONE;
      end
   end

   // Pause debounce: accept a press on the sampled pattern old=0, new two=1
   assign deb_shift_nxt = {deb_shift[1:0], pause_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_shift   <= '0;
         pause_pulse <= 1'b0;
      end else begin
         if (deb_tick)
            deb_shift <= deb_shift_nxt;
         pause_pulse <= deb_tick && (deb_shift_nxt == 3'b011);
      end
   end

   // Mode FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_PAUSE;
         run_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         run_flag <= run_flag_nxt;
      end
   end

   // Next state and strobes; strobes follow the current state
   always_comb begin
      run_flag_nxt = run_flag;
      state_nxt    = state;
      sec_inc_nxt  = 1'b0;
      min_inc_nxt  = 1'b0;
      in_adj       = (state == ST_ADJ_MIN) || (state == ST_ADJ_SEC);

      if (pause_pulse && !adj_s)
         run_flag_nxt = !run_flag;

      if (adj_s)
         state_nxt = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
      else
         state_nxt = run_flag_nxt ? ST_RUN : ST_PAUSE;

      adj_entry = ((state_nxt == ST_ADJ_MIN) || (state_nxt == ST_ADJ_SEC)) &&
                  (state_nxt != state);

      if (!clr_s) begin
         case (state)
            ST_RUN: begin
               sec_inc_nxt = run_tick;
               min_inc_nxt = run_tick && sec_wrap;
            end
            ST_ADJ_SEC: sec_inc_nxt = adj_tick;
            ST_ADJ_MIN: min_inc_nxt = adj_tick;
            default: begin
               sec_inc_nxt = 1'b0;
               min_inc_nxt = 1'b0;
            end
         endcase
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_inc     <= 1'b0;
         min_inc     <= 1'b0;
         running     <= 1'b0;
         blink_en    <= 1'b0;
         scan_en     <= 1'b0;
         blink_phase <= 1'b0;
      end else begin
         sec_inc     <= sec_inc_nxt;
         min_inc     <= min_inc_nxt;
         running     <= (state_nxt == ST_RUN);
         blink_en    <= (state_nxt == ST_ADJ_MIN) || (state_nxt == ST_ADJ_SEC);
         scan_en     <= scan_tick;
         if (blink_tick)
            blink_phase <= !blink_phase;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers; outputs sampled on negedge.
module tb_stopwatch_ctrl;

   logic clk, rst_n;
   logic btn_pause, btn_clr, adj, sel, sec_wrap;
   logic sec_inc, min_inc, clr, blink_en, blink_phase, scan_en, running;

   stopwatch_ctrl #(
      .RUN_DIV(10), .ADJ_DIV(4), .BLINK_DIV(3), .SCAN_DIV(2), .DEB_DIV(2), .CNT_W(27)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_clr(btn_clr),
      .adj(adj), .sel(sel), .sec_wrap(sec_wrap), .sec_inc(sec_inc),
      .min_inc(min_inc), .clr(clr), .blink_en(blink_en),
      .blink_phase(blink_phase), .scan_en(scan_en), .running(running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int sec_n, min_n, scan_n, blink_tog, rise_n;
   int last_sec = -1, last_min = -1, last_scan = -1, last_blink = -1;
   int sec_bad, min_bad, scan_bad, blink_bad;
   int sec_period = 10, min_period = 10;
   logic prev_blink = 1'b0, prev_run = 1'b0;
   int s_cyc, f_cyc, r_cyc, frozen;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      sec_n = 0; min_n = 0; scan_n = 0; blink_tog = 0; rise_n = 0;
      sec_bad = 0; min_bad = 0; scan_bad = 0; blink_bad = 0;
      last_min = -1; last_scan = -1; last_blink = -1;
   endtask

   // Advance n cycles, sampling outputs at each negedge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (sec_inc) begin
            if (last_sec >= 0 && cyc - last_sec != sec_period) sec_bad++;
            last_sec = cyc; sec_n++;
         end
         if (min_inc) begin
            if (last_min >= 0 && cyc - last_min != min_period) min_bad++;
            last_min = cyc; min_n++;
         end
         if (scan_en) begin
            if (last_scan >= 0 && cyc - last_scan != 2) scan_bad++;
            last_scan = cyc; scan_n++;
         end
         if (blink_phase !== prev_blink) begin
            if (last_blink >= 0 && cyc - last_blink != 3) blink_bad++;
            last_blink = cyc; blink_tog++;
         end
         prev_blink = blink_phase;
         if (running && !prev_run) rise_n++;
         prev_run = running;
      end
   endtask

   task automatic wait_sec(input int limit);
      for (int i = 0; i < limit; i++) begin
         step(1);
         if (sec_inc) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; btn_pause = 1'b0; btn_clr = 1'b0;
      adj = 1'b0; sel = 1'b0; sec_wrap = 1'b0;
      clear_stats();
      step(3);
      check("rst_outs", int'({sec_inc, min_inc, clr, blink_en, blink_phase, scan_en, running}), 0);

      // Idle after reset
      rst_n = 1'b1;
      clear_stats();
      step(100);
      check("idle_running", running, 0);
      check("idle_strobes", sec_n + min_n, 0);
      check("idle_scan_cnt", scan_n, 50);
      check("idle_scan_gap", scan_bad, 0);
      check("idle_blink_gap", blink_bad, 0);
      check("idle_blink_cnt", int'(blink_tog >= 33), 1);

      // Bouncy press, then hold: exactly one accepted press
      clear_stats();
      btn_pause = 1'b1; step(1);
      btn_pause = 1'b0; step(1);
      btn_pause = 1'b1; step(20);
      check("press_rises", rise_n, 1);
      check("press_running", running, 1);
      btn_pause = 1'b0; step(10);
      check("release_running", running, 1);
      check("release_rises", rise_n, 1);

      // RUN cadence without and with carry
      clear_stats(); sec_period = 10;
      step(35);
      check("run_sec_cnt", int'(sec_n >= 3), 1);
      check("run_sec_gap", sec_bad, 0);
      check("run_no_min", min_n, 0);
      sec_wrap = 1'b1; step(2);
      clear_stats(); min_period = 10;
      step(30);
      check("carry_sec_cnt", sec_n, 3);
      check("carry_min_cnt", min_n, 3);
      check("carry_min_gap", min_bad, 0);
      sec_wrap = 1'b0;

      // Pause shortly after a second tick, stay paused, resume
      wait_sec(20);
      check("pause_sync_sec", sec_inc, 1);
      btn_pause = 1'b1;
      for (int i = 0; i < 30 && running; i++) step(1);
      check("pause_fell", running, 0);
      f_cyc = cyc;
      frozen = f_cyc - last_sec;
      clear_stats();
      step(6);
      btn_pause = 1'b0;
      step(44);
      check("paused_strobes", sec_n + min_n, 0);
      check("paused_running", running, 0);
      btn_pause = 1'b1;
      for (int i = 0; i < 30 && !running; i++) step(1);
      check("resume_rose", running, 1);
      r_cyc = cyc;
      wait_sec(20);
      check("resume_sec_seen", sec_inc, 1);
      check("resume_delay", cyc - r_cyc, 10 - frozen);
      btn_pause = 1'b0;
      step(10);

      // Adjust minutes, then seconds, then leave adjust
      adj = 1'b1; sel = 1'b0;
      step(8);
      check("adjm_blink_en", blink_en, 1);
      check("adjm_running", running, 0);
      clear_stats(); min_period = 4;
      step(24);
      check("adjm_min_cnt", min_n, 6);
      check("adjm_min_gap", min_bad, 0);
      check("adjm_no_sec", sec_n, 0);
      sel = 1'b1; sec_wrap = 1'b1;
      step(8);
      clear_stats(); sec_period = 4;
      step(24);
      check("adjs_sec_cnt", sec_n, 6);
      check("adjs_sec_gap", sec_bad, 0);
      check("adjs_no_min", min_n, 0);
      check("adjs_blink_en", blink_en, 1);
      adj = 1'b0; sel = 1'b0; sec_wrap = 1'b0;
      step(6);
      check("adj_exit_running", running, 1);
      check("adj_exit_blink", blink_en, 0);
      sec_period = 10; min_period = 10;

      // Clear held in RUN
      btn_clr = 1'b1;
      step(1);
      check("clr_lat1", clr, 0);
      step(1);
      check("clr_lat2", clr, 1);
      clear_stats();
      step(30);
      check("clr_strobes", sec_n + min_n, 0);
      btn_clr = 1'b0;
      for (int i = 0; i < 10 && clr; i++) step(1);
      check("clr_released", clr, 0);
      s_cyc = cyc;
      wait_sec(20);
      check("clr_sec_seen", sec_inc, 1);
      check("clr_resume_delay", cyc - s_cyc, 10);
      check("clr_running", running, 1);

      // Reset in the cycle before a run tick
      wait_sec(20);
      step(8);
      rst_n = 1'b0;
      #1;
      check("midrst_outs", int'({sec_inc, min_inc, clr, blink_en, blink_phase, scan_en, running}), 0);
      step(2);
      rst_n = 1'b1;
      step(5);
      clear_stats();
      step(30);
      check("midrst_running", running, 0);
      check("midrst_strobes", sec_n + min_n, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
